plab4_net_router_ring_param: RTL and testbench

//  Parametrised successor to the 3-port ring router. One router per ring node.

---
 rtl/plab4_net_router_ring_param_pkg.sv | 24 ++
 rtl/plab4_net_router_ring_param_queue.sv | 80 ++++++++
 rtl/plab4_net_router_rr_out_ctrl.sv | 73 +++++++
 rtl/plab4_net_router_ring_param.sv | 157 +++++++++++++++
 tb/tb_plab4_net_router_ring_param.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/plab4_net_router_ring_param_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : plab4_net_router_ring_param_pkg                             |
// | Desc    : Shared constants and helpers for the parametrised ring      |
// |           router: port indices and ring modular distance.             |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package plab4_net_router_ring_param_pkg;

  // Router port indices (input and output sides share numbering)
  localparam logic [1:0] c_WEST = 2'd0;
  localparam logic [1:0] c_TERM = 2'd1;
  localparam logic [1:0] c_EAST = 2'd2;

  // Eastward hop count from id to dest on a ring of n nodes.
  // dest + n - id never overflows s+1 bits, so this equals the narrow form.
  function automatic int unsigned mod_dist(input int unsigned dest,
                                           input int unsigned id,
                                           input int unsigned n);
    return (dest + n - id) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/plab4_net_router_ring_param_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : plab4_net_router_ring_param_queue                           |
// | Desc    : Non-bypass FIFO with parametrised depth and a free-entry    |
// |           count; ready is simply !full and is held low in reset.      |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module plab4_net_router_ring_param_queue #(
  parameter int p_msg_nbits = 41,
  parameter int p_depth     = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enq_val_i,
  output logic                             enq_rdy_o,
  input  logic [p_msg_nbits-1:0]           enq_msg_i,
  output logic                             deq_val_o,
  input  logic                             deq_rdy_i,
  output logic [p_msg_nbits-1:0]           deq_msg_o,
  output logic [$clog2(p_depth+1)-1:0]     num_free_o
);

  localparam int c_PTR_W = $clog2(p_depth);
  localparam int c_CNT_W = $clog2(p_depth+1);
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(p_depth);
  localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(p_depth-1);

  logic [p_msg_nbits-1:0] mem_q [p_depth];
  logic [c_PTR_W-1:0]     head_q, head_d;
  logic [c_PTR_W-1:0]     tail_q, tail_d;
  logic [c_CNT_W-1:0]     cnt_q, cnt_d;
  logic                   w_full, w_enq, w_deq;

  // Pointers wrap explicitly so non-power-of-two depths work
  function automatic logic [c_PTR_W-1:0] bump(input logic [c_PTR_W-1:0] p);
    return (p == c_LAST) ? '0 : p + c_PTR_W'(1);
  endfunction

  assign w_full     = (cnt_q == c_DEPTH);
  assign enq_rdy_o  = reset & ~w_full;
  assign deq_val_o  = (cnt_q != '0);
  assign deq_msg_o  = mem_q[head_q];
  assign num_free_o = c_DEPTH - cnt_q;
  assign w_enq      = enq_val_i & enq_rdy_o;
  assign w_deq      = deq_val_o & deq_rdy_i;

  // Next pointer and occupancy from this cycle's enqueue/dequeue
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (w_enq) tail_d = bump(tail_q);
    if (w_deq) head_d = bump(head_q);
    case ({w_enq, w_deq})
      2'b10:   cnt_d = cnt_q + c_CNT_W'(1);
      2'b01:   cnt_d = cnt_q - c_CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset empties the queue
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage write; contents are meaningless while the count says empty
  always_ff @(posedge clk) begin
    if (w_enq) mem_q[tail_q] <= enq_msg_i;
  end

endmodule
`default_nettype wire

// File: rtl/plab4_net_router_rr_out_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : plab4_net_router_rr_out_ctrl                                |
// | Desc    : Per-output control: 3-way round-robin arbiter, priority     |
// |           pointer, crossbar select and 16-bit forwarded count.        |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module plab4_net_router_rr_out_ctrl
  import plab4_net_router_ring_param_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req_i,
  input  logic        out_rdy_i,
  output logic        out_val_o,
  output logic [2:0]  grant_o,
  output logic [1:0]  sel_o,
  output logic [15:0] count_o
);

  logic [1:0]  ptr_q, ptr_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  w_o0, w_o1, w_o2;
  logic        w_xfer;

  // Search order starting at the pointer, then grant the first requester
  always_comb begin
    grant_o = 3'b000;
    sel_o   = c_WEST;
    case (ptr_q)
      2'd1:    begin w_o0 = 2'd1; w_o1 = 2'd2; w_o2 = 2'd0; end
      2'd2:    begin w_o0 = 2'd2; w_o1 = 2'd0; w_o2 = 2'd1; end
      default: begin w_o0 = 2'd0; w_o1 = 2'd1; w_o2 = 2'd2; end
    endcase
    if (req_i[w_o0]) begin
      grant_o[w_o0] = 1'b1;
      sel_o         = w_o0;
    end else if (req_i[w_o1]) begin
      grant_o[w_o1] = 1'b1;
      sel_o         = w_o1;
    end else if (req_i[w_o2]) begin
      grant_o[w_o2] = 1'b1;
      sel_o         = w_o2;
    end
  end

  assign out_val_o = |req_i;
  assign w_xfer    = out_val_o & out_rdy_i;
  assign count_o   = count_q;

  // Pointer moves past the winner and the count bumps only on a transfer
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (w_xfer) begin
      ptr_d   = (sel_o == c_EAST) ? c_WEST : sel_o + 2'd1;
      count_d = count_q + 16'd1;
    end
  end

  // Pointer and counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q   <= 2'd0;
      count_q <= 16'd0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/plab4_net_router_ring_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : plab4_net_router_ring_param                                 |
// | Desc    : 3-port ring router (0=west, 1=terminal, 2=east) with input  |
// |           queues, shortest-path injection, bubble flow control and    |
// |           round-robin output arbitration.                             |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module plab4_net_router_ring_param
  import plab4_net_router_ring_param_pkg::*;
#(
  parameter int p_payload_nbits = 32,
  parameter int p_opaque_nbits  = 3,
  parameter int p_srcdest_nbits = 3,
  parameter int p_router_id     = 0,
  parameter int p_num_routers   = 8,
  parameter int p_queue_depth   = 4,
  parameter int p_bubble        = 2,
  localparam int c_M = p_payload_nbits + p_opaque_nbits + 2*p_srcdest_nbits
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in0_val_i,
  output logic           in0_rdy_o,
  input  logic [c_M-1:0] in0_msg_i,
  input  logic           in1_val_i,
  output logic           in1_rdy_o,
  input  logic [c_M-1:0] in1_msg_i,
  input  logic           in2_val_i,
  output logic           in2_rdy_o,
  input  logic [c_M-1:0] in2_msg_i,
  output logic           out0_val_o,
  input  logic           out0_rdy_i,
  output logic [c_M-1:0] out0_msg_o,
  output logic [15:0]    out0_count_o,
  output logic           out1_val_o,
  input  logic           out1_rdy_i,
  output logic [c_M-1:0] out1_msg_o,
  output logic [15:0]    out1_count_o,
  output logic           out2_val_o,
  input  logic           out2_rdy_i,
  output logic [c_M-1:0] out2_msg_o,
  output logic [15:0]    out2_count_o
);

  localparam int c_S      = p_srcdest_nbits;
  localparam int c_FREE_W = $clog2(p_queue_depth+1);
  localparam logic [c_S-1:0]      c_ID     = c_S'(p_router_id);
  localparam logic [c_FREE_W-1:0] c_BUBBLE = c_FREE_W'(p_bubble);
  localparam int unsigned         c_HALF   = p_num_routers / 2;

  logic [2:0]          w_in_val, w_in_rdy, w_out_rdy, w_out_val;
  logic [c_M-1:0]      w_in_msg   [3];
  logic [2:0]          w_head_val, w_deq_rdy, w_allow;
  logic [c_M-1:0]      w_head_msg [3];
  logic [c_FREE_W-1:0] w_free     [3];
  logic [1:0]          w_route    [3];
  logic [2:0]          w_req      [3];
  logic [2:0]          w_grant    [3];
  logic [1:0]          w_sel      [3];
  logic [15:0]         w_count    [3];
  logic [c_M-1:0]      w_out_msg  [3];

  assign w_in_val    = {in2_val_i, in1_val_i, in0_val_i};
  assign w_in_msg[0] = in0_msg_i;
  assign w_in_msg[1] = in1_msg_i;
  assign w_in_msg[2] = in2_msg_i;
  assign {in2_rdy_o, in1_rdy_o, in0_rdy_o} = w_in_rdy;
  assign w_out_rdy   = {out2_rdy_i, out1_rdy_i, out0_rdy_i};
  assign {out2_val_o, out1_val_o, out0_val_o} = w_out_val;
  assign out0_msg_o  = w_out_msg[0];
  assign out1_msg_o  = w_out_msg[1];
  assign out2_msg_o  = w_out_msg[2];
  assign out0_count_o = w_count[0];
  assign out1_count_o = w_count[1];
  assign out2_count_o = w_count[2];

  // A head requests one output, so at most one grant term is live
  assign w_deq_rdy = (w_grant[0] & {3{w_out_rdy[0]}})
                   | (w_grant[1] & {3{w_out_rdy[1]}})
                   | (w_grant[2] & {3{w_out_rdy[2]}});

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_in
      plab4_net_router_ring_param_queue #(
        .p_msg_nbits (c_M),
        .p_depth     (p_queue_depth)
      ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .enq_val_i  (w_in_val[gi]),
        .enq_rdy_o  (w_in_rdy[gi]),
        .enq_msg_i  (w_in_msg[gi]),
        .deq_val_o  (w_head_val[gi]),
        .deq_rdy_i  (w_deq_rdy[gi]),
        .deq_msg_o  (w_head_msg[gi]),
        .num_free_o (w_free[gi])
      );

      if (gi == 1) begin : g_term
        logic [c_S-1:0] w_dest;
        int unsigned    w_de;
        assign w_dest = w_head_msg[gi][c_M-1 -: c_S];
        // Injection takes the shorter way round; equal distance goes east
        always_comb begin
          w_de = mod_dist(32'(w_dest), p_router_id, p_num_routers);
          if (w_dest == c_ID)      w_route[gi] = c_TERM;
          else if (w_de <= c_HALF) w_route[gi] = c_EAST;
          else                     w_route[gi] = c_WEST;
        end
        // Leave a bubble in the ring queue we would enter so the ring keeps moving
        always_comb begin
          w_allow[gi] = 1'b1;
          if (w_route[gi] == c_EAST)      w_allow[gi] = (w_free[0] >= c_BUBBLE);
          else if (w_route[gi] == c_WEST) w_allow[gi] = (w_free[2] >= c_BUBBLE);
        end
      end else begin : g_ring
        logic [c_S-1:0] w_dest;
        assign w_dest = w_head_msg[gi][c_M-1 -: c_S];
        // Ring traffic continues in its direction of travel unless it has arrived
        always_comb begin
          if (w_dest == c_ID) w_route[gi] = c_TERM;
          else                w_route[gi] = (gi == 0) ? c_EAST : c_WEST;
        end
        assign w_allow[gi] = 1'b1;
      end
    end

    for (genvar go = 0; go < 3; go++) begin : g_out
      for (genvar gr = 0; gr < 3; gr++) begin : g_req
        assign w_req[go][gr] = w_head_val[gr] & w_allow[gr] & (w_route[gr] == 2'(go));
      end

      plab4_net_router_rr_out_ctrl u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .req_i     (w_req[go]),
        .out_rdy_i (w_out_rdy[go]),
        .out_val_o (w_out_val[go]),
        .grant_o   (w_grant[go]),
        .sel_o     (w_sel[go]),
        .count_o   (w_count[go])
      );

      // Crossbar column: forward the selected queue head
      always_comb begin
        case (w_sel[go])
          2'd1:    w_out_msg[go] = w_head_msg[1];
          2'd2:    w_out_msg[go] = w_head_msg[2];
          default: w_out_msg[go] = w_head_msg[0];
        endcase
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_plab4_net_router_ring_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_plab4_net_router_ring_param                              |
// | Desc    : Self-checking bench: queue-level reference model compared   |
// |           every cycle, plus directed literal expectations.            |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_plab4_net_router_ring_param;

  localparam int P  = 32;
  localparam int O  = 3;
  localparam int S  = 3;
  localparam int ID = 2;
  localparam int N  = 8;
  localparam int D  = 4;
  localparam int B  = 2;
  localparam int M  = P + O + 2*S;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [2:0]       in_val = '0, in_rdy, out_val, out_rdy = '0;
  logic [2:0][M-1:0] in_msg = '0, out_msg;
  logic [2:0][15:0] out_cnt;

  always #5 clk = ~clk;

  plab4_net_router_ring_param #(
    .p_payload_nbits (P), .p_opaque_nbits (O), .p_srcdest_nbits (S),
    .p_router_id (ID), .p_num_routers (N), .p_queue_depth (D), .p_bubble (B)
  ) dut (
    .clk (clk), .reset (reset),
    .in0_val_i (in_val[0]), .in0_rdy_o (in_rdy[0]), .in0_msg_i (in_msg[0]),
    .in1_val_i (in_val[1]), .in1_rdy_o (in_rdy[1]), .in1_msg_i (in_msg[1]),
    .in2_val_i (in_val[2]), .in2_rdy_o (in_rdy[2]), .in2_msg_i (in_msg[2]),
    .out0_val_o (out_val[0]), .out0_rdy_i (out_rdy[0]), .out0_msg_o (out_msg[0]), .out0_count_o (out_cnt[0]),
    .out1_val_o (out_val[1]), .out1_rdy_i (out_rdy[1]), .out1_msg_o (out_msg[1]), .out1_count_o (out_cnt[1]),
    .out2_val_o (out_val[2]), .out2_rdy_i (out_rdy[2]), .out2_msg_o (out_msg[2]), .out2_count_o (out_cnt[2])
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Reference model state: message queues, RR pointers, counters
  logic [M-1:0] mq [3][$];
  int  ptr [3];
  int  cnt [3];
  bit  e_val [3];
  int  e_src [3];
  bit  e_rdy [3];

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0h required=%0h at %0t", nm, idx, act, exp, $time);
    end
  endtask

  function automatic logic [M-1:0] mk(input int dest, input int tag);
    logic [M-1:0] m;
    m = '0;
    m[M-1 -: S] = S'(dest);
    m[P-1:0]    = P'(tag);
    return m;
  endfunction

  function automatic int route_of(input int i, input logic [M-1:0] m);
    int dest, de;
    dest = int'(m[M-1 -: S]);
    if (dest == ID) return 1;
    if (i == 0) return 2;
    if (i == 2) return 0;
    de = ((dest - ID) % N + N) % N;
    return (de <= N/2) ? 2 : 0;
  endfunction

  function automatic bit wants(input int i, input int o);
    if (mq[i].size() == 0) return 1'b0;
    if (route_of(i, mq[i][0]) != o) return 1'b0;
    if (i == 1 && o == 2) return (D - mq[0].size()) >= B;
    if (i == 1 && o == 0) return (D - mq[2].size()) >= B;
    return 1'b1;
  endfunction

  // Compare process: predict outputs from model state and check each cycle
  initial begin
    forever begin
      @(negedge clk);
      for (int o = 0; o < 3; o++) begin
        e_val[o] = 1'b0;
        e_src[o] = 0;
        for (int k = 0; k < 3; k++) begin
          int i;
          i = (ptr[o] + k) % 3;
          if (!e_val[o] && wants(i, o)) begin
            e_val[o] = 1'b1;
            e_src[o] = i;
          end
        end
      end
      for (int i = 0; i < 3; i++) e_rdy[i] = reset && (mq[i].size() < D);
      if (chk_en) begin
        for (int o = 0; o < 3; o++) begin
          chk("out_val", o, 64'(out_val[o]), 64'(e_val[o]));
          if (e_val[o]) chk("out_msg", o, 64'(out_msg[o]), 64'(mq[e_src[o]][0]));
          chk("out_count", o, 64'(out_cnt[o]), 64'(cnt[o]));
          chk("in_rdy", o, 64'(in_rdy[o]), 64'(e_rdy[o]));
        end
      end
    end
  end

  // Model update at each active edge
  initial begin
    for (int i = 0; i < 3; i++) begin ptr[i] = 0; cnt[i] = 0; end
    forever begin
      @(posedge clk);
      if (!reset) begin
        for (int i = 0; i < 3; i++) begin
          mq[i].delete();
          ptr[i] = 0;
          cnt[i] = 0;
        end
      end else begin
        for (int o = 0; o < 3; o++) begin
          if (e_val[o] && out_rdy[o]) begin
            void'(mq[e_src[o]].pop_front());
            ptr[o] = (e_src[o] + 1) % 3;
            cnt[o] = (cnt[o] + 1) & 16'hFFFF;
          end
        end
        for (int i = 0; i < 3; i++)
          if (in_val[i] && e_rdy[i]) mq[i].push_back(in_msg[i]);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    in_val = '0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  int t_in  [9] = '{1, 1, 1, 0, 2, 1, 1, 2, 0};
  int t_dst [9] = '{5, 7, 6, 3, 2, 1, 3, 4, 2};
  int t_out [9] = '{2, 0, 2, 2, 1, 0, 2, 0, 1};

  // Stimulus
  initial begin
    // Reset held with all inputs valid
    in_val = 3'b111;
    in_msg[0] = mk(3, 1); in_msg[1] = mk(5, 2); in_msg[2] = mk(2, 3);
    out_rdy = 3'b111;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_rdy", 0, 64'(in_rdy), 64'(0));
    chk("rst_out_val", 0, 64'(out_val), 64'(0));
    chk("rst_count", 2, 64'(out_cnt[2]), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    in_val = '0;
    @(negedge clk);
    chk("post_rst_val", 0, 64'(out_val), 64'(0));
    chk("post_rst_rdy", 0, 64'(in_rdy), 64'(7));

    // Local delivery, one-cycle latency
    @(posedge clk); #1;
    in_val[1] = 1'b1; in_msg[1] = mk(2, 'hABCD);
    @(posedge clk); #1;
    in_val[1] = 1'b0;
    @(negedge clk);
    chk("local_val", 1, 64'(out_val), 64'(3'b010));
    chk("local_msg", 1, 64'(out_msg[1]), 64'(mk(2, 'hABCD)));
    @(posedge clk);
    @(negedge clk);
    chk("local_count", 1, 64'(out_cnt[1]), 64'(1));

    // Route table
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      in_val[t_in[k]] = 1'b1;
      in_msg[t_in[k]] = mk(t_dst[k], k);
      @(posedge clk); #1;
      in_val = '0;
      @(negedge clk);
      chk("route_val", k, 64'(out_val), 64'(1 << t_out[k]));
    end

    // Two streams onto the east output alternate under round robin
    @(posedge clk); #1;
    do_reset();
    in_msg[0] = mk(3, 0); in_msg[1] = mk(5, 1);
    in_val = 3'b011; out_rdy = 3'b111;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c < 4) chk("rr_src", c, 64'(out_msg[2][P-1:0]), 64'(c % 2));
    end
    chk("rr_count", 2, 64'(out_cnt[2]), 64'(8));

    // Bubble threshold: in0 holds 3 (free=1), injection east is blocked
    @(posedge clk); #1;
    do_reset();
    out_rdy = 3'b101;
    in_val[0] = 1'b1; in_msg[0] = mk(2, 9);
    repeat (3) @(posedge clk);
    #1;
    in_val[0] = 1'b0;
    in_val[1] = 1'b1; in_msg[1] = mk(5, 7);
    @(posedge clk); #1;
    in_val[1] = 1'b0;
    @(negedge clk);
    chk("bubble_block", 2, 64'(out_val), 64'(3'b010));
    @(posedge clk); #1;
    out_rdy = 3'b111;
    @(negedge clk);
    chk("bubble_hold", 2, 64'(out_val[2]), 64'(0));
    @(posedge clk);
    @(negedge clk);
    chk("bubble_open", 2, 64'(out_val[2]), 64'(1));
    chk("bubble_msg", 2, 64'(out_msg[2][P-1:0]), 64'(7));

    // Backpressure on the terminal output: queue fills after 4, order kept
    @(posedge clk); #1;
    do_reset();
    out_rdy = 3'b101;
    in_val[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_msg[0] = mk(2, k);
      @(posedge clk); #1;
    end
    in_val[0] = 1'b0;
    @(negedge clk);
    chk("bp_rdy", 0, 64'(in_rdy[0]), 64'(0));
    @(posedge clk); #1;
    out_rdy = 3'b111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_order", k, 64'(out_msg[1][P-1:0]), 64'(k));
      @(posedge clk);
    end
    @(negedge clk);
    chk("bp_drained", 1, 64'(out_val[1]), 64'(0));
    chk("bp_count", 1, 64'(out_cnt[1]), 64'(4));

    // Randomized traffic with occasional mid-stream reset
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      reset   = ($urandom_range(0, 199) != 0);
      in_val  = 3'($urandom);
      out_rdy = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      for (int i = 0; i < 3; i++)
        in_msg[i] = mk(int'($urandom_range(0, N-1)), int'($urandom));
    end
    @(posedge clk); #1;
    reset = 1'b1;
    in_val = '0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
